// File: rtl/dot_product_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_acc_if
// Description : Product-in / frame-sum-out handshake bundle for dot_product_acc.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_product_acc_if #(
    parameter int ACC_W = 24
);
    logic [15:0]      prod;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;

    modport master (
        output prod, in_valid, out_ready,
        input  in_ready, acc_out, out_valid, ovf
    );

    modport slave (
        input  prod, in_valid, out_ready,
        output in_ready, acc_out, out_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/dot_product_acc.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_acc
// Description : Saturating accumulator summing N_TERMS unsigned 16-bit products
//               per frame, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_acc #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 24
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clr,
    dot_product_acc_if.slave bus
);
    localparam int                 c_CNT_W = $clog2(N_TERMS) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N_TERMS - 1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic               r_in_ready;

    logic [ACC_W:0]     w_sum;
    logic               w_sat;
    logic               w_accept;
    logic               w_last;

    // One spare bit catches the carry out of the accumulator.
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, bus.prod};
    assign w_sat    = w_sum[ACC_W] || r_ovf;
    assign w_accept = bus.in_valid && r_in_ready;
    assign w_last   = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
                        r_ovf <= w_sat;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (w_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // The result is held until consumed; the new frame opens a cycle later.
                    if (bus.out_ready) begin
                        r_state     <= ACCUM;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.acc_out   = r_acc;
    assign bus.out_valid = r_out_valid;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire
